riscv_commit_reporter: RTL and testbench
========================================

// Module: riscv_commit_reporter
// PURPOSE
//   Producer side of the CPU-to-bench retire-report interface (NUM_INST / OUTPUT_PORT / HALT).
//   It sits inside RISCV_TOP, next to the multicycle control FSM, and is pulsed once per completed instruction.
//   It counts retired instructions and registers a per-instruction result word.
//   It detects the two-instruction halt signature and asserts a sticky HALT.
// PARAMETERS
//   CNT_WIDTH   32             width of NUM_INST; the counter wraps modulo 2^CNT_WIDTH
//   HALT_INST0  32'h00c00093   first halt-signature word (addi x1,x0,12)
//   HALT_INST1  32'h00008067   second halt-signature word (jalr x0,0(x1))
// PORTS
//   CLK          in   1          clock; all state updates on rising edge
//   RST          in   1          synchronous reset, active-high; has priority over every other input
//   RETIRE       in   1          1 = the instruction in INST completes this cycle (pulse; back-to-back allowed)
//   INST         in   32         instruction word being retired; valid only when RETIRE=1
//   RF_WE        in   1          register-file write enable of the retiring instruction
//   RF_WD        in   32         register-file write data of the retiring instruction
//   D_MEM_WEN    in   1          data-memory write enable, active-low (0 = store in progress)
//   D_MEM_ADDR   in   12         data-memory address of the retiring store
//   BR_TAKEN     in   1          branch condition result of the retiring branch
//   NUM_INST     out  CNT_WIDTH  count of retired instructions
//   OUTPUT_PORT  out  32         result word of the most recently retired instruction
//   HALT         out  1          1 = halt signature retired; sticky until RST
// BEHAVIOUR
//   Reset (RST=1 at a rising edge):
//     - NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE.
//     - Applies even when RETIRE=1 in the same cycle; that retire is dropped.
//   Accept condition: a retire is accepted when RETIRE=1, RST=0 and HALT=0.
//   All outputs are registered.
//     - An accepted retire in cycle N is visible on NUM_INST, OUTPUT_PORT and HALT after edge N+1.
//     - NUM_INST and OUTPUT_PORT always update on the same edge, so the bench sees a consistent pair.
//   NUM_INST: +1 per accepted retire; wraps from all-ones to 0; holds when there is no accepted retire.
//   OUTPUT_PORT on an accepted retire, selected by opcode = INST[6:0]:
//     - 0110011 / 0010011 / 0000011 / 0110111 / 0010111 / 1101111 / 1100111 (ALU, load, LUI, AUIPC, JAL, JALR): RF_WD.
//       RF_WD is used regardless of RF_WE, so an rd=x0 write still reports RF_WD.
//     - 0100011 (store): {20'b0, D_MEM_ADDR}. D_MEM_WEN must be 0 here; if it is 1, OUTPUT_PORT holds its value.
//     - 1100011 (branch): {31'b0, BR_TAKEN}.
//     - Any other opcode: OUTPUT_PORT holds; NUM_INST still increments.
//   Halt FSM (transitions only on accepted retires; otherwise the state holds):
//     - IDLE   --INST==HALT_INST0--> SEEN0; any other INST stays in IDLE.
//     - SEEN0  --INST==HALT_INST1--> HALTED.
//       INST==HALT_INST0 stays in SEEN0 (repeated first word).
//       Any other INST returns to IDLE.
//     - HALTED: HALT=1, taken on the same edge that counts the HALT_INST1 retire.
//       Later RETIRE pulses are ignored; NUM_INST and OUTPUT_PORT freeze. Only RST exits.
//   The HALT_INST1 instruction is counted and reported like any other instruction (JALR reports RF_WD).
//   Non-retire cycles between HALT_INST0 and HALT_INST1 do not break the signature.
//   Inputs other than RETIRE and RST are don't-care when RETIRE=0.
// TESTING
//   1. RST held 3 cycles, then released with RETIRE=0 -> NUM_INST=0, OUTPUT_PORT=0, HALT=0 for 10 cycles.
//   2. Retire addi (INST=32'h00500093, RF_WD=5), then slti (RF_WD=0) -> NUM_INST=1/OUTPUT_PORT=5, then NUM_INST=2/OUTPUT_PORT=0, each one edge after RETIRE.
//   3. Store sw (opcode 0100011, D_MEM_WEN=0, D_MEM_ADDR=12'h2C0), then beq with BR_TAKEN=1
//      -> OUTPUT_PORT=32'h000002C0, then 32'h00000001.
//   4. Halt sequence: retire 00c00093, 2 idle cycles, 00008067 with RF_WD=32'h10 -> HALT=1 with NUM_INST=+2 and OUTPUT_PORT=32'h10.
//      A further RETIRE changes nothing.
//   5. Near-miss sequences 00c00093, 00000013, 00008067 -> HALT stays 0; NUM_INST counts all 3.
//      Also 00c00093, 00c00093, 00008067 -> HALT=1.
//   6. RST=1 coincident with RETIRE after HALT -> all outputs 0 next edge.
//      With CNT_WIDTH=4, 17 retires -> NUM_INST=1 (wrap).

Source files
------------

// File: rtl/riscv_commit_reporter_if.sv
// Retire-report bus between the multicycle control FSM (master) and the
// commit reporter (slave). Carries the per-instruction retire information
// in one direction and the registered report outputs in the other.
interface riscv_commit_reporter_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 RETIRE;
  logic [31:0]          INST;
  logic                 RF_WE;
  logic [31:0]          RF_WD;
  logic                 D_MEM_WEN;
  logic [11:0]          D_MEM_ADDR;
  logic                 BR_TAKEN;
  logic [CNT_WIDTH-1:0] NUM_INST;
  logic [31:0]          OUTPUT_PORT;
  logic                 HALT;

  modport master (
    output RETIRE, INST, RF_WE, RF_WD, D_MEM_WEN, D_MEM_ADDR, BR_TAKEN,
    input  NUM_INST, OUTPUT_PORT, HALT
  );

  modport slave (
    input  RETIRE, INST, RF_WE, RF_WD, D_MEM_WEN, D_MEM_ADDR, BR_TAKEN,
    output NUM_INST, OUTPUT_PORT, HALT
  );
endinterface

// File: rtl/riscv_commit_reporter.sv
// Commit reporter: counts retired instructions, registers a per-instruction
// result word and raises a sticky HALT once the two-word halt signature
// (HALT_INST0 followed by HALT_INST1) has retired.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no partial halt signature seen
//   ST_SEEN0  | last accepted retire was HALT_INST0
//   ST_HALTED | signature complete; HALT=1, retires ignored until RST
module riscv_commit_reporter #(
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] HALT_INST0 = 32'h00c00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
  input logic                      CLK,
  input logic                      RST,
  riscv_commit_reporter_if.slave   rpt
);

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEN0  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t               state_q;
  logic                 halt_q;
  logic [CNT_WIDTH-1:0] num_inst_q, num_inst_d;
  logic [31:0]          output_port_q, output_port_d;
  logic                 accept;
  logic                 unused_rf_we;

  // RF_WD is reported regardless of the write enable (rd=x0 still reports).
  assign unused_rf_we = rpt.RF_WE;

  assign accept = rpt.RETIRE & ~halt_q;

  // Next count and next result word for an accepted retire.
  always_comb begin
    num_inst_d    = num_inst_q;
    output_port_d = output_port_q;
    if (accept) begin
      num_inst_d = num_inst_q + CNT_WIDTH'(1);
      case (rpt.INST[6:0])
        OP_ALU, OP_ALUI, OP_LOAD, OP_LUI,
        OP_AUIPC, OP_JAL, OP_JALR: output_port_d = rpt.RF_WD;
        OP_STORE: begin
          if (!rpt.D_MEM_WEN) output_port_d = {20'b0, rpt.D_MEM_ADDR};
        end
        OP_BRANCH: output_port_d = {31'b0, rpt.BR_TAKEN};
        default:   output_port_d = output_port_q;
      endcase
    end
  end

  // Report registers and halt-signature FSM; reset wins over any retire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      halt_q        <= 1'b0;
      num_inst_q    <= '0;
      output_port_q <= '0;
    end else if (accept) begin
      num_inst_q    <= num_inst_d;
      output_port_q <= output_port_d;
      case (state_q)
        ST_IDLE: begin
          if (rpt.INST == HALT_INST0) state_q <= ST_SEEN0;
        end
        ST_SEEN0: begin
          if (rpt.INST == HALT_INST1) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end else if (rpt.INST != HALT_INST0) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign rpt.NUM_INST    = num_inst_q;
  assign rpt.OUTPUT_PORT = output_port_q;
  assign rpt.HALT        = halt_q;

endmodule

// File: tb/tb_riscv_commit_reporter.sv
// Bench for riscv_commit_reporter: a 32-bit-counter instance and a 4-bit
// counter instance share one stimulus stream and are compared against a
// behavioural model of the retire-report rules.
module tb_riscv_commit_reporter;

  localparam logic [31:0] H0 = 32'h00c00093;
  localparam logic [31:0] H1 = 32'h00008067;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire = 1'b0;
  logic [31:0] inst = '0;
  logic        rf_we = 1'b0;
  logic [31:0] rf_wd = '0;
  logic        d_mem_wen = 1'b1;
  logic [11:0] d_mem_addr = '0;
  logic        br_taken = 1'b0;

  int passed = 0;
  int total  = 0;

  // behavioural model
  logic [31:0] m_cnt = '0;
  logic [31:0] m_out = '0;
  logic        m_halt = 1'b0;
  logic        m_last_h0 = 1'b0;

  riscv_commit_reporter_if #(.CNT_WIDTH(32)) bus32 ();
  riscv_commit_reporter_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus32.RETIRE = retire;     assign bus4.RETIRE = retire;
  assign bus32.INST = inst;         assign bus4.INST = inst;
  assign bus32.RF_WE = rf_we;       assign bus4.RF_WE = rf_we;
  assign bus32.RF_WD = rf_wd;       assign bus4.RF_WD = rf_wd;
  assign bus32.D_MEM_WEN = d_mem_wen;   assign bus4.D_MEM_WEN = d_mem_wen;
  assign bus32.D_MEM_ADDR = d_mem_addr; assign bus4.D_MEM_ADDR = d_mem_addr;
  assign bus32.BR_TAKEN = br_taken; assign bus4.BR_TAKEN = br_taken;

  riscv_commit_reporter #(.CNT_WIDTH(32)) dut32 (.CLK(clk), .RST(rst), .rpt(bus32));
  riscv_commit_reporter #(.CNT_WIDTH(4))  dut4  (.CLK(clk), .RST(rst), .rpt(bus4));

  always #5 clk = ~clk;

  // Snapshot of everything observable, packed for one-line comparison.
  function automatic logic [68:0] observed();
    return {bus32.NUM_INST, bus32.OUTPUT_PORT, bus32.HALT, bus4.NUM_INST};
  endfunction

  function automatic logic [68:0] modelled();
    logic [31:0] c;
    c = m_cnt;
    return {m_cnt, m_out, m_halt, c[3:0]};
  endfunction

  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                      7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  // One retire cycle; the model is updated from the rules after the edge.
  task automatic do_retire(input logic [31:0] ins, input logic [31:0] wd,
                           input logic wen, input logic [11:0] addr, input logic br);
    @(negedge clk);
    retire = 1'b1; inst = ins; rf_we = 1'($urandom); rf_wd = wd;
    d_mem_wen = wen; d_mem_addr = addr; br_taken = br;
    @(posedge clk);
    #1;
    retire = 1'b0;
    if (rst) begin
      m_cnt = '0; m_out = '0; m_halt = 1'b0; m_last_h0 = 1'b0;
    end else if (!m_halt) begin
      m_cnt = m_cnt + 1;
      if (writes_rd(ins[6:0]))                   m_out = wd;
      else if (ins[6:0] == 7'b0100011 && !wen)   m_out = {20'b0, addr};
      else if (ins[6:0] == 7'b1100011)           m_out = {31'b0, br};
      if (m_last_h0 && ins == H1) m_halt = 1'b1;
      m_last_h0 = (ins == H0);
    end
  endtask

  task automatic do_idle();
    @(negedge clk);
    retire = 1'b0; inst = $urandom; rf_we = 1'($urandom); rf_wd = $urandom;
    d_mem_wen = 1'($urandom); d_mem_addr = 12'($urandom); br_taken = 1'($urandom);
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = '0; m_out = '0; m_halt = 1'b0; m_last_h0 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    do_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) do_idle();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_idle();
      total++;
      if (observed() !== 69'd0)
        $display("FAIL reset_idle cycle %0d: got %h, expected %h", i, observed(), 69'd0);
      else passed++;
    end
  endtask

  task automatic test_alu();
    do_reset();
    do_retire(32'h00500093, 32'd5, 1'b1, 12'h0, 1'b0);
    total++;
    if (observed() !== {32'd1, 32'd5, 1'b0, 4'd1})
      $display("FAIL alu_addi: got %h, expected %h", observed(), {32'd1, 32'd5, 1'b0, 4'd1});
    else passed++;
    do_retire(32'h00a0a113, 32'd0, 1'b1, 12'h0, 1'b0);
    total++;
    if (observed() !== {32'd2, 32'd0, 1'b0, 4'd2})
      $display("FAIL alu_slti: got %h, expected %h", observed(), {32'd2, 32'd0, 1'b0, 4'd2});
    else passed++;
  endtask

  task automatic test_store_branch();
    do_retire(32'h00112023, 32'hdead_beef, 1'b0, 12'h2C0, 1'b0);
    total++;
    if (bus32.OUTPUT_PORT !== 32'h000002C0 || observed() !== modelled())
      $display("FAIL store_addr: got %h, expected %h", observed(), modelled());
    else passed++;
    do_retire(32'h00000063, 32'h1234_5678, 1'b1, 12'h0, 1'b1);
    total++;
    if (bus32.OUTPUT_PORT !== 32'h00000001 || observed() !== modelled())
      $display("FAIL branch_taken: got %h, expected %h", observed(), modelled());
    else passed++;
    do_retire(32'h00112023, 32'h0, 1'b1, 12'h555, 1'b0);
    total++;
    if (bus32.OUTPUT_PORT !== 32'h00000001 || observed() !== modelled())
      $display("FAIL store_wen_high_hold: got %h, expected %h", observed(), modelled());
    else passed++;
    do_retire(32'h0000000F, 32'hffff_ffff, 1'b0, 12'h7, 1'b1);
    total++;
    if (bus32.OUTPUT_PORT !== 32'h00000001 || observed() !== modelled())
      $display("FAIL other_opcode_hold: got %h, expected %h", observed(), modelled());
    else passed++;
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b1110011};
    logic [31:0] ins;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 3) do_idle();
      else begin
        ins = {25'($urandom), ops[$urandom_range(0, 9)]};
        if (ins == H0 || ins == H1) ins[31] = ~ins[31];
        do_retire(ins, $urandom, 1'($urandom), 12'($urandom), 1'($urandom));
      end
      total++;
      if (observed() !== modelled())
        $display("FAIL random step %0d: got %h, expected %h", i, observed(), modelled());
      else passed++;
    end
  endtask

  task automatic test_halt();
    logic [68:0] frozen;
    do_reset();
    do_retire(H0, 32'd12, 1'b1, 12'h0, 1'b0);
    do_idle();
    do_idle();
    total++;
    if (bus32.HALT !== 1'b0)
      $display("FAIL halt_early: got %b, expected 0", bus32.HALT);
    else passed++;
    do_retire(H1, 32'h10, 1'b1, 12'h0, 1'b0);
    total++;
    if (observed() !== {32'd2, 32'h10, 1'b1, 4'd2})
      $display("FAIL halt_seq: got %h, expected %h", observed(), {32'd2, 32'h10, 1'b1, 4'd2});
    else passed++;
    frozen = observed();
    for (int i = 0; i < 4; i++) begin
      do_retire(32'h00500093, $urandom, 1'b0, 12'($urandom), 1'($urandom));
      total++;
      if (observed() !== {32'd2, 32'h10, 1'b1, 4'd2} || observed() !== modelled())
        $display("FAIL halt_frozen %0d: got %h, expected %h", i, observed(), frozen);
      else passed++;
    end
  endtask

  task automatic test_near_miss();
    do_reset();
    do_retire(H0, 32'd12, 1'b1, 12'h0, 1'b0);
    do_retire(NOP, 32'd0, 1'b1, 12'h0, 1'b0);
    do_retire(H1, 32'h20, 1'b1, 12'h0, 1'b0);
    total++;
    if (observed() !== {32'd3, 32'h20, 1'b0, 4'd3})
      $display("FAIL near_miss: got %h, expected %h", observed(), {32'd3, 32'h20, 1'b0, 4'd3});
    else passed++;
    do_reset();
    do_retire(H0, 32'd12, 1'b1, 12'h0, 1'b0);
    do_retire(H0, 32'd12, 1'b1, 12'h0, 1'b0);
    do_retire(H1, 32'h30, 1'b1, 12'h0, 1'b0);
    total++;
    if (observed() !== {32'd3, 32'h30, 1'b1, 4'd3})
      $display("FAIL repeated_h0: got %h, expected %h", observed(), {32'd3, 32'h30, 1'b1, 4'd3});
    else passed++;
  endtask

  task automatic test_reset_retire();
    total++;
    if (bus32.HALT !== 1'b1)
      $display("FAIL pre_reset_halted: got %b, expected 1", bus32.HALT);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    do_retire(32'h00500093, 32'd5, 1'b1, 12'h0, 1'b0);
    total++;
    if (observed() !== 69'd0)
      $display("FAIL reset_with_retire: got %h, expected %h", observed(), 69'd0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++)
      do_retire(32'h00100093 + (i << 20), i, 1'b1, 12'h0, 1'b0);
    total++;
    if (bus4.NUM_INST !== 4'd1 || bus32.NUM_INST !== 32'd17 || observed() !== modelled())
      $display("FAIL wrap: got %h, expected %h", observed(), modelled());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_branch();
    test_random();
    test_halt();
    test_near_miss();
    test_reset_retire();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
